// File: rtl/pipelined_adder.sv
// pipelined_adder: block-wise carry-lookahead adder/subtractor, one pipeline stage per BLOCK bits.
module pipelined_adder #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);
  localparam int L = WIDTH / BLOCK;

  function automatic logic [BLOCK:0] cla(input logic [BLOCK-1:0] x, input logic [BLOCK-1:0] y, input logic cin);
    logic [BLOCK-1:0] g, p;
    logic [BLOCK:0] c;
    logic t;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i];
      t = p[i];
      for (int m = i - 1; m >= 0; m--) begin
        c[i+1] = c[i+1] | (t & g[m]);
        t = t & p[m];
      end
      c[i+1] = c[i+1] | (t & cin);
    end
    return c;
  endfunction

  logic en;
  logic [L-1:0] v_q, v_d, c_q, c_d;
  logic ovf_q, ovf_d;
  logic [WIDTH-1:0] bx, sum_w;

  assign out_valid = v_q[L-1];
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  assign bx = sub ? ~b : b;

  genvar j;
  for (j = 0; j < L; j++) begin : g_st
    logic [BLOCK-1:0] as, bs;
    logic cin;
    logic [BLOCK:0] cv;
    logic [BLOCK-1:0] r_q [L-j];
    logic [BLOCK-1:0] r_d [L-j];
    if (j == 0) begin : g_in
      assign as = a[BLOCK-1:0];
      assign bs = bx[BLOCK-1:0];
      assign cin = sub | ci;
    end else begin : g_skew
      // operand slice j waits j cycles so it meets the carry rippling up from below
      logic [BLOCK-1:0] ak_q [j];
      logic [BLOCK-1:0] ak_d [j];
      logic [BLOCK-1:0] bk_q [j];
      logic [BLOCK-1:0] bk_d [j];
      always_comb begin
        ak_d[0] = a[j*BLOCK +: BLOCK];
        bk_d[0] = bx[j*BLOCK +: BLOCK];
        for (int i = 1; i < j; i++) begin
          ak_d[i] = ak_q[i-1];
          bk_d[i] = bk_q[i-1];
        end
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ak_q <= '{default: '0};
          bk_q <= '{default: '0};
        end else if (en) begin
          ak_q <= ak_d;
          bk_q <= bk_d;
        end
      end
      assign as = ak_q[j-1];
      assign bs = bk_q[j-1];
      assign cin = c_q[j-1];
    end
    assign cv = cla(as, bs, cin);
    assign c_d[j] = cv[BLOCK];
    always_comb begin
      r_d[0] = (as ^ bs) ^ cv[BLOCK-1:0];
      for (int i = 1; i < L - j; i++) r_d[i] = r_q[i-1];
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_q <= '{default: '0};
      else if (en) r_q <= r_d;
    end
    assign sum_w[j*BLOCK +: BLOCK] = r_q[L-j-1];
    if (j == L - 1) begin : g_ovf
      assign ovf_d = cv[BLOCK] ^ cv[BLOCK-1];
    end
  end

  assign v_d = (v_q << 1) | L'(in_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      v_q <= v_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum = sum_w;
  assign co = c_q[L-1];
  assign ovf = ovf_q;
  assign zero = (sum_w == '0);
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed table, back-pressure, mid-flight reset and random scoreboard checks.
module tb_pipelined_adder;
  logic clk, rst, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf, zero;
  logic [7:0] a, b, sum;

  pipelined_adder #(.WIDTH(8), .BLOCK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .co(co), .ovf(ovf), .zero(zero)
  );

  typedef struct {logic [7:0] s; logic co, ovf, z;} res_t;
  typedef struct {logic [7:0] a, b; logic ci, sub; logic [7:0] s; logic co, ovf, z;} vec_t;

  res_t exp_q[$];
  int total = 0, passed = 0, nout = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    res_t r;
    logic [7:0] yy;
    logic [8:0] t;
    yy = s ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + {8'b0, s | c};
    r.s = t[7:0];
    r.co = t[8];
    r.ovf = (x[7] == yy[7]) && (t[7] != x[7]);
    r.z = (t[7:0] == 8'h00);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ici, input logic isub, input logic ordy, output logic acc);
    res_t e;
    in_valid = iv; a = ia; b = ib; ci = ici; sub = isub; out_ready = ordy;
    #1;
    acc = iv && in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_sum", sum, e.s);
        chk("sb_co", co, e.co);
        chk("sb_ovf", ovf, e.ovf);
        chk("sb_zero", zero, e.z);
        nout++;
      end
    end
    if (acc) exp_q.push_back(model(ia, ib, ici, isub));
  endtask

  vec_t tv[11];
  logic acc;
  logic [7:0] held;
  logic [7:0] bpa[4], bpb[4];
  res_t r;
  int idx, stalls, n0;
  logic stall;

  initial begin
    tv[0]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    tv[1]  = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    tv[5]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    tv[8]  = '{8'h33, 8'h33, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    tv[9]  = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};
    tv[10] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    bpa = '{8'h11, 8'hF0, 8'h7F, 8'h33};
    bpb = '{8'h22, 8'h10, 8'h7F, 8'h44};

    rst = 1; in_valid = 0; a = 0; b = 0; ci = 0; sub = 0; out_ready = 1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_co", co, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 1);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst = 0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1; a = tv[i].a; b = tv[i].b; ci = tv[i].ci; sub = tv[i].sub; out_ready = 1;
      #1 chk("vec_in_ready", in_ready, 1);
      @(negedge clk); in_valid = 0;
      #1 chk("vec_latency_early", out_valid, 0);
      @(negedge clk); #1;
      chk("vec_out_valid", out_valid, 1);
      chk("vec_sum", sum, tv[i].s);
      chk("vec_co", co, tv[i].co);
      chk("vec_ovf", ovf, tv[i].ovf);
      chk("vec_zero", zero, tv[i].z);
    end
    @(negedge clk); #1 chk("vec_drained", out_valid, 0);

    idx = 0; stalls = 0; n0 = nout; held = 0;
    for (int cyc = 0; cyc < 40 && (idx < 4 || exp_q.size() != 0); cyc++) begin
      @(negedge clk);
      stall = out_valid && stalls < 3;
      step(idx < 4, bpa[idx % 4], bpb[idx % 4], 1'b0, 1'b0, !stall, acc);
      if (stall) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        if (stalls > 0) chk("bp_sum_hold", sum, held);
        held = sum;
        stalls++;
      end
      if (acc) idx++;
    end
    chk("bp_count", nout - n0, 4);
    chk("bp_queue_empty", exp_q.size(), 0);

    @(negedge clk); step(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk); step(1, 8'h56, 8'h78, 1'b0, 1'b1, 1'b1, acc);
    @(negedge clk); in_valid = 0;
    #1 chk("pre_rst_valid", out_valid, 1);
    #1 rst = 1;
    #1 chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", sum, 0);
    exp_q.delete();
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); step(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc);
      chk("post_rst_quiet", out_valid, 0);
    end
    @(negedge clk);
    in_valid = 1; a = 8'h9C; b = 8'h64; ci = 1'b1; sub = 1'b0; out_ready = 1;
    #1 chk("post_rst_accept", in_ready, 1);
    r = model(8'h9C, 8'h64, 1'b1, 1'b0);
    @(negedge clk); in_valid = 0;
    #1 chk("post_rst_lat1", out_valid, 0);
    @(negedge clk); #1;
    chk("post_rst_lat2", out_valid, 1);
    chk("post_rst_sum", sum, r.s);
    chk("post_rst_co", co, r.co);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, acc);
    end
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk); step(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    end
    chk("rand_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
